icache_refill_unit: RTL and testbench

Memory-side refill engine that sits directly downstream of the instruction cache controller's miss interface. It accepts a single-cycle line request (32-byte aligned address) and fetches the 8 words of that line over a narrow 32-bit word-read bus. It assembles the words into a 256-bit line and returns it with a one-cycle ready pulse, which the cache consumes as `mem_data_in` / `mem_ready_in`. Only one refill is outstanding at a time.

---
 rtl/icache_pkg.sv | 22 ++
 rtl/refill_word_ctr.sv | 35 +++
 rtl/icache_refill_unit.sv | 111 +++++++++++
 tb/tb_icache_refill_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared constants and state encoding for the instruction-cache refill engine.
// Latency: n/a (package). Backpressure: n/a.
package icache_pkg;

    localparam int LINE_WORDS = 8;
    localparam int OFFSET_W   = 5;
    localparam int WORD_SEL_W = 3;
    localparam int BASE_W     = 27;

    localparam logic [1:0] ST_IDLE      = 2'b00;
    localparam logic [1:0] ST_ISSUE     = 2'b01;
    localparam logic [1:0] ST_WAIT_DATA = 2'b10;
    localparam logic [1:0] ST_DONE      = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        ISSUE     = ST_ISSUE,
        WAIT_DATA = ST_WAIT_DATA,
        DONE      = ST_DONE
    } refill_state_t;

endpackage

// File: rtl/refill_word_ctr.sv
// Wrapping word pointer plus words-done count for one line refill.
// Latency: load/inc take effect next edge. Backpressure: none, driven by the refill FSM.
module refill_word_ctr
    import icache_pkg::*;
#(
    parameter int SEL_W = WORD_SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SEL_W-1:0] start,
    input  logic             inc,
    output logic [SEL_W-1:0] ptr,
    output logic             last
);

    logic [SEL_W:0] done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            done_q <= '0;
        end else if (load) begin
            ptr    <= start;
            done_q <= '0;
        end else if (inc) begin
            // pointer wraps inside the line; the done count never does before a reload
            ptr    <= ptr + SEL_W'(1);
            done_q <= done_q + (SEL_W + 1)'(1);
        end
    end

    assign last = (done_q == {1'b0, {SEL_W{1'b1}}});

endmodule

// File: rtl/icache_refill_unit.sv
// Fetches one cache line word-by-word over a narrow read bus; ICACHE_REFILL_CWF_EN enables critical-word-first.
// Latency: 1 + 2*WORDS_PER_LINE cycles with zero-wait memory. Backpressure: one refill at a time, req_in ignored while busy.
module icache_refill_unit
    import icache_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int WORD_W         = 32,
    parameter int WORDS_PER_LINE = LINE_WORDS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_in,
    input  logic [ADDR_W-1:0]                addr_in,
    output logic [WORD_W*WORDS_PER_LINE-1:0] line_out,
    output logic                             ready_out,
    output logic                             busy_out,
    output logic                             mem_rd_req_out,
    output logic [ADDR_W-1:0]                mem_rd_addr_out,
    input  logic                             mem_rd_gnt_in,
    input  logic                             mem_rd_valid_in,
    input  logic [WORD_W-1:0]                mem_rd_data_in
);

    localparam int SEL_W     = $clog2(WORDS_PER_LINE);
    localparam int BYTE_W    = $clog2(WORD_W / 8);
    localparam int OFF_W     = SEL_W + BYTE_W;
    localparam int LBASE_W   = ADDR_W - OFF_W;

    refill_state_t        state_q, state_nxt;
    logic [LBASE_W-1:0]   base_q;
    logic [SEL_W-1:0]     ptr;
    logic [SEL_W-1:0]     start_word;
    logic                 ctr_load;
    logic                 ctr_inc;
    logic                 last_word;
    logic                 unused_addr_bits;

`ifdef ICACHE_REFILL_CWF_EN
    assign start_word = addr_in[OFF_W-1:BYTE_W];
`else
    assign start_word = '0;
`endif

    assign unused_addr_bits = ^addr_in[OFF_W-1:0];

    refill_word_ctr #(
        .SEL_W (SEL_W)
    ) u_word_ctr (
        .clk   (clk),
        .rst   (rst),
        .load  (ctr_load),
        .start (start_word),
        .inc   (ctr_inc),
        .ptr   (ptr),
        .last  (last_word)
    );

    always_comb begin
        state_nxt = state_q;
        ctr_load  = 1'b0;
        ctr_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_in) begin
                    ctr_load  = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_rd_gnt_in) begin
                    state_nxt = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (mem_rd_valid_in) begin
                    ctr_inc   = 1'b1;
                    state_nxt = last_word ? DONE : ISSUE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            base_q   <= '0;
            line_out <= '0;
        end else begin
            state_q <= state_nxt;
            if (ctr_load) begin
                base_q <= addr_in[ADDR_W-1:OFF_W];
            end
            // each word lands in its own slot, so fetch order never changes the final line
            if (ctr_inc) begin
                line_out[ptr*WORD_W +: WORD_W] <= mem_rd_data_in;
            end
        end
    end

    assign ready_out       = (state_q == DONE);
    assign busy_out        = (state_q != IDLE);
    assign mem_rd_req_out  = (state_q == ISSUE);
    assign mem_rd_addr_out = {base_q, ptr, {BYTE_W{1'b0}}};

endmodule

// File: tb/tb_icache_refill_unit.sv
// Randomized bench for icache_refill_unit with a line-level reference model and a reactive memory driver.
// Latency and ordering are checked every cycle against the model's expected fetch sequence.
module tb_icache_refill_unit;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_in;
    logic [31:0]  addr_in;
    logic [255:0] line_out;
    logic         ready_out;
    logic         busy_out;
    logic         mem_rd_req_out;
    logic [31:0]  mem_rd_addr_out;
    logic         mem_rd_gnt_in;
    logic         mem_rd_valid_in;
    logic [31:0]  mem_rd_data_in;

    int n_chk  = 0;
    int n_fail = 0;
    int rdy_cnt = 0;
    logic [255:0] model_line = '0;

    always #5 clk = ~clk;

    icache_refill_unit dut (
        .clk             (clk),
        .rst             (rst),
        .req_in          (req_in),
        .addr_in         (addr_in),
        .line_out        (line_out),
        .ready_out       (ready_out),
        .busy_out        (busy_out),
        .mem_rd_req_out  (mem_rd_req_out),
        .mem_rd_addr_out (mem_rd_addr_out),
        .mem_rd_gnt_in   (mem_rd_gnt_in),
        .mem_rd_valid_in (mem_rd_valid_in),
        .mem_rd_data_in  (mem_rd_data_in)
    );

    always @(negedge clk) if (ready_out === 1'b1) rdy_cnt++;

    task automatic check_val(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_line"},  line_out, '0);
        check_val({tag, "_ready"}, ready_out, 1'b0);
        check_val({tag, "_busy"},  busy_out, 1'b0);
        check_val({tag, "_rdreq"}, mem_rd_req_out, 1'b0);
        check_val({tag, "_rdaddr"}, mem_rd_addr_out, 32'h0);
    endtask

    // One full refill. gmax/vmax: wait cycles before gnt/valid (fixed or random up to).
    // abort_at < 8 asserts reset when that word is about to be requested.
    task automatic refill(input logic [31:0] addr, input int gmax, input int vmax,
                          input bit rnd_dly, input bit noise, input int abort_at, input bit pat);
        logic [31:0]  words [8];
        logic [255:0] exp_line;
        logic [31:0]  exp_addr;
        int start, slot, g, v, r0;
`ifdef ICACHE_REFILL_CWF_EN
        start = int'(addr[4:2]);
`else
        start = 0;
`endif
        exp_line = model_line;
        for (int s = 0; s < 8; s++) words[s] = pat ? (32'hA000_0000 + 32'(s)) : $urandom;

        req_in  = 1'b1;
        addr_in = addr;
        step();
        req_in  = 1'b0;
        addr_in = $urandom;
        r0 = rdy_cnt;
        check_val("busy_after_req", busy_out, 1'b1);

        for (int k = 0; k < 8; k++) begin
            slot     = (start + k) % 8;
            exp_addr = {addr[31:5], 5'b0} + 32'(slot * 4);
            g = rnd_dly ? $urandom_range(0, gmax) : gmax;
            v = rnd_dly ? $urandom_range(0, vmax) : vmax;

            if (k == abort_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                check_reset_outputs("abort");
                mem_rd_valid_in = 1'b1;
                mem_rd_data_in  = $urandom;
                step();
                mem_rd_valid_in = 1'b0;
                check_reset_outputs("late_valid");
                model_line = '0;
                return;
            end

            for (int i = 0; i <= g; i++) begin
                check_val("rd_req_issue", mem_rd_req_out, 1'b1);
                check_val("rd_addr", mem_rd_addr_out, exp_addr);
                check_val("ready_early", ready_out, 1'b0);
                mem_rd_gnt_in = (i == g);
                if (noise) begin
                    mem_rd_valid_in = 1'($urandom_range(0, 1));
                    mem_rd_data_in  = $urandom;
                    req_in          = 1'($urandom_range(0, 1));
                    addr_in         = $urandom;
                end
                step();
            end
            mem_rd_gnt_in = 1'b0;
            mem_rd_valid_in = 1'b0;
            req_in = 1'b0;

            for (int i = 0; i <= v; i++) begin
                check_val("rd_req_wait", mem_rd_req_out, 1'b0);
                check_val("ready_early", ready_out, 1'b0);
                mem_rd_valid_in = (i == v);
                mem_rd_data_in  = (i == v) ? words[slot] : $urandom;
                if (noise) begin
                    mem_rd_gnt_in = 1'($urandom_range(0, 1));
                    req_in        = 1'($urandom_range(0, 1));
                end
                step();
            end
            mem_rd_valid_in = 1'b0;
            mem_rd_gnt_in   = 1'b0;
            req_in          = 1'b0;
            exp_line[slot*32 +: 32] = words[slot];
        end

        check_val("ready_pulse", ready_out, 1'b1);
        check_val("busy_done", busy_out, 1'b1);
        check_val("rd_req_done", mem_rd_req_out, 1'b0);
        check_val("line_done", line_out, exp_line);
        if (noise) begin
            req_in          = 1'b1;
            mem_rd_valid_in = 1'b1;
            mem_rd_data_in  = $urandom;
        end
        step();
        req_in = 1'b0;
        check_val("ready_drop", ready_out, 1'b0);
        check_val("busy_idle", busy_out, 1'b0);
        check_val("line_hold", line_out, exp_line);
        mem_rd_valid_in = 1'b1;
        mem_rd_data_in  = $urandom;
        step();
        mem_rd_valid_in = 1'b0;
        check_val("line_idle_valid", line_out, exp_line);
        check_val("busy_idle2", busy_out, 1'b0);
        check_val("rd_req_idle", mem_rd_req_out, 1'b0);
        check_val("ready_count", 32'(rdy_cnt - r0), 32'd1);
        model_line = exp_line;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_in          = 1'($urandom_range(0, 1));
            addr_in         = $urandom;
            mem_rd_gnt_in   = 1'($urandom_range(0, 1));
            mem_rd_valid_in = 1'($urandom_range(0, 1));
            mem_rd_data_in  = $urandom;
            step();
            check_reset_outputs("reset");
        end
        rst = 1'b0;
        req_in = 1'b0;
        addr_in = '0;
        mem_rd_gnt_in = 1'b0;
        mem_rd_valid_in = 1'b0;
        mem_rd_data_in = '0;
        step();
        check_reset_outputs("idle");

        refill(32'h0000_1234, 0, 0, 1'b0, 1'b0, 8, 1'b1);
        check_val("basic_w0", line_out[31:0], 32'hA000_0000);
        check_val("basic_w7", line_out[255:224], 32'hA000_0007);

        refill(32'h0000_1234, 3, 4, 1'b0, 1'b0, 8, 1'b1);
        check_val("stall_w7", line_out[255:224], 32'hA000_0007);

        refill(32'h0000_4460, 0, 0, 1'b0, 1'b1, 8, 1'b0);

        refill(32'h0000_1234, 0, 0, 1'b0, 1'b0, 3, 1'b0);
        refill(32'h0000_2000, 0, 0, 1'b0, 1'b0, 8, 1'b1);

        refill(32'h0000_1314, 1, 1, 1'b0, 1'b0, 8, 1'b1);
        check_val("cwf_w0", line_out[31:0], 32'hA000_0000);

        for (int n = 0; n < 6; n++) begin
            refill($urandom, 3, 3, 1'b1, 1'b1, 8, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
